// File: rtl/adc_scan_sequencer.sv
// Dual-ADC two-slot scan sequencer: settle, SOC, EOC wait with timeout, 2^AVG_LOG2 averaging.
// All outputs registered; results strobe for one cycle with no backpressure, values held until next EMIT.
module adc_scan_sequencer #(
  parameter int         AVG_LOG2    = 2,
  parameter int         SETTLE_CYC  = 4,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [3:0] S0_CH0      = 4'd0,
  parameter logic [3:0] S0_CH1      = 4'd8,
  parameter logic [3:0] S1_CH0      = 4'd1,
  parameter logic [3:0] S1_CH1      = 4'd9
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        enable_i,
  input  logic        cal_rdy_i,
  input  logic        adc_eoc_i,
  input  logic [11:0] adc0_data_i,
  input  logic [11:0] adc1_data_i,
  input  logic        err_clr_i,
  output logic [3:0]  adc0_ch_sel_o,
  output logic [3:0]  adc1_ch_sel_o,
  output logic        adc_soc_o,
  output logic        adc_convstop_o,
  output logic        res_valid_o,
  output logic        res_slot_o,
  output logic [11:0] res0_o,
  output logic [11:0] res1_o,
  output logic        err_timeout_o,
  output logic        busy_o
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0]      TO_LAST     = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_CAL, SETUP, START, WAIT_EOC, CAPTURE, EMIT
  } state_t;

  state_t           state, state_n;
  logic             slot, slot_n;
  logic             to_hit;
  logic [7:0]       settle_cnt;
  logic [15:0]      to_cnt;
  logic [CNT_W-1:0] samp_cnt;
  logic [ACC_W-1:0] acc0, acc1, acc0_sum, acc1_sum;
  logic [11:0]      d0_q, d1_q;

  assign acc0_sum = acc0 + ACC_W'(d0_q);
  assign acc1_sum = acc1 + ACC_W'(d1_q);

  always_comb begin
    state_n = state;
    slot_n  = slot;
    to_hit  = 1'b0;
    case (state)
      IDLE:     if (enable_i) state_n = WAIT_CAL;
      WAIT_CAL: if (cal_rdy_i) state_n = SETUP;
      SETUP:    if (settle_cnt == SETTLE_LAST) state_n = START;
      START:    state_n = WAIT_EOC;
      WAIT_EOC: begin
        // EOC takes priority over a timeout expiring in the same cycle
        if (adc_eoc_i) begin
          state_n = CAPTURE;
        end else if (to_cnt == TO_LAST) begin
          to_hit  = 1'b1;
          slot_n  = ~slot;
          state_n = SETUP;
        end
      end
      CAPTURE:  state_n = (samp_cnt == LAST_CNT) ? EMIT : START;
      EMIT: begin
        slot_n  = ~slot;
        state_n = SETUP;
      end
      default:  state_n = IDLE;
    endcase
    if (state != IDLE && !enable_i) begin
      state_n = IDLE;
      to_hit  = 1'b0;
    end
    if (state_n == IDLE) slot_n = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state          <= IDLE;
      slot           <= 1'b0;
      settle_cnt     <= '0;
      to_cnt         <= '0;
      samp_cnt       <= '0;
      acc0           <= '0;
      acc1           <= '0;
      d0_q           <= '0;
      d1_q           <= '0;
      adc0_ch_sel_o  <= S0_CH0;
      adc1_ch_sel_o  <= S0_CH1;
      adc_soc_o      <= 1'b0;
      adc_convstop_o <= 1'b1;
      busy_o         <= 1'b0;
      res_valid_o    <= 1'b0;
      res_slot_o     <= 1'b0;
      res0_o         <= '0;
      res1_o         <= '0;
      err_timeout_o  <= 1'b0;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      settle_cnt <= (state == SETUP) ? settle_cnt + 8'd1 : '0;
      to_cnt     <= (state == WAIT_EOC) ? to_cnt + 16'd1 : '0;

      if (state_n == CAPTURE) begin
        d0_q <= adc0_data_i;
        d1_q <= adc1_data_i;
      end

      // Abort, timeout and completed emit all start the next slot from zero
      if (state_n == IDLE || to_hit || state == EMIT) begin
        acc0     <= '0;
        acc1     <= '0;
        samp_cnt <= '0;
      end else if (state == CAPTURE) begin
        acc0     <= acc0_sum;
        acc1     <= acc1_sum;
        samp_cnt <= samp_cnt + CNT_W'(1);
      end

      if (state_n == SETUP && state != SETUP) begin
        adc0_ch_sel_o <= slot_n ? S1_CH0 : S0_CH0;
        adc1_ch_sel_o <= slot_n ? S1_CH1 : S0_CH1;
      end

      adc_soc_o      <= (state_n == START);
      adc_convstop_o <= (state_n == IDLE) || (state_n == WAIT_CAL) || to_hit;
      busy_o         <= (state_n != IDLE);
      res_valid_o    <= (state_n == EMIT);

      // Final CAPTURE already knows the full sum, so the result lands with the EMIT strobe
      if (state_n == EMIT) begin
        res0_o     <= acc0_sum[ACC_W-1:AVG_LOG2];
        res1_o     <= acc1_sum[ACC_W-1:AVG_LOG2];
        res_slot_o <= slot;
      end

      if (to_hit)         err_timeout_o <= 1'b1;
      else if (err_clr_i) err_timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: table of slot averages plus timeout/abort/reset sequences.
module tb_adc_scan_sequencer;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk;
  logic        resetn, enable, cal_rdy, eoc, err_clr;
  logic [11:0] d0, d1;
  logic [3:0]  ch0, ch1;
  logic        soc, convstop, valid, rslot, err, busy;
  logic [11:0] r0, r1;

  logic        en_b, cal_b, eoc_b, clr_b;
  logic [11:0] d0_b, d1_b;
  logic [3:0]  ch0_b, ch1_b;
  logic        soc_b, convstop_b, valid_b, rslot_b, err_b, busy_b;
  logic [11:0] r0_b, r1_b;

  int n_vec  = 0;
  int n_miss = 0;
  int soc_cnt = 0;
  int valid_cnt = 0;

  adc_scan_sequencer #(.AVG_LOG2(2), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .cal_rdy_i(cal_rdy),
    .adc_eoc_i(eoc), .adc0_data_i(d0), .adc1_data_i(d1), .err_clr_i(err_clr),
    .adc0_ch_sel_o(ch0), .adc1_ch_sel_o(ch1), .adc_soc_o(soc), .adc_convstop_o(convstop),
    .res_valid_o(valid), .res_slot_o(rslot), .res0_o(r0), .res1_o(r1),
    .err_timeout_o(err), .busy_o(busy)
  );

  adc_scan_sequencer #(.AVG_LOG2(0), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut_avg1 (
    .clk_i(clk), .resetn_i(resetn), .enable_i(en_b), .cal_rdy_i(cal_b),
    .adc_eoc_i(eoc_b), .adc0_data_i(d0_b), .adc1_data_i(d1_b), .err_clr_i(clr_b),
    .adc0_ch_sel_o(ch0_b), .adc1_ch_sel_o(ch1_b), .adc_soc_o(soc_b), .adc_convstop_o(convstop_b),
    .res_valid_o(valid_b), .res_slot_o(rslot_b), .res0_o(r0_b), .res1_o(r1_b),
    .err_timeout_o(err_b), .busy_o(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (soc === 1'b1) soc_cnt++;
    if (valid === 1'b1) valid_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0][11:0] d0;
    logic [3:0][11:0] d1;
    logic [15:0]      tc;
    logic [3:0]       ch0;
    logic [3:0]       ch1;
    logic             slot;
    logic [11:0]      r0;
    logic [11:0]      r1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_soc(input bit b, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((b ? soc_b : soc) !== 1'b1) && n < 3000);
    if ((b ? soc_b : soc) !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL soc_wait: no SOC within %0d cycles", n);
    end
  endtask

  // Entered at the negedge of a START cycle; leaves at the negedge of the CAPTURE cycle.
  task automatic do_sample(input logic [11:0] a, input logic [11:0] b, input int tc);
    repeat (tc) @(negedge clk);
    eoc = 1'b1;
    d0  = a;
    d1  = b;
    @(negedge clk);
    eoc = 1'b0;
    d0  = 12'd77;
    d1  = 12'd77;
  endtask

  task automatic run_vec(input vec_t v);
    int s0;
    s0 = soc_cnt;
    check("ch0_sel", ch0, v.ch0);
    check("ch1_sel", ch1, v.ch1);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        @(negedge clk);
        check("soc_after_capture", soc, 1);
      end
      do_sample(v.d0[s], v.d1[s], int'(v.tc));
    end
    @(negedge clk);
    check("res_valid", valid, 1);
    check("res_slot", rslot, v.slot);
    check("res0", r0, v.r0);
    check("res1", r1, v.r1);
    check("soc_per_slot", soc_cnt - s0, 4);
  endtask

  task automatic check_reset();
    check("rst_ch0", ch0, 0);
    check("rst_ch1", ch1, 8);
    check("rst_soc", soc, 0);
    check("rst_convstop", convstop, 1);
    check("rst_valid", valid, 0);
    check("rst_slot", rslot, 0);
    check("rst_res0", r0, 0);
    check("rst_res1", r1, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    int n, v0, s0;

    vecs[0] = '{d0: {12'd103, 12'd102, 12'd101, 12'd100}, d1: {4{12'd4000}}, tc: 16'd20,
                ch0: 4'd0, ch1: 4'd8, slot: 1'b0, r0: 12'd101, r1: 12'd4000};
    vecs[1] = '{d0: {4{12'd4095}}, d1: {12'd3, 12'd2, 12'd1, 12'd0}, tc: 16'd3,
                ch0: 4'd1, ch1: 4'd9, slot: 1'b1, r0: 12'd4095, r1: 12'd1};
    vecs[2] = '{d0: {12'd0, 12'd0, 12'd0, 12'd7}, d1: {12'd4094, 12'd4095, 12'd4095, 12'd4095}, tc: 16'd1,
                ch0: 4'd0, ch1: 4'd8, slot: 1'b0, r0: 12'd1, r1: 12'd4094};
    vecs[3] = '{d0: {12'd5, 12'd3, 12'd2, 12'd1}, d1: {12'd2051, 12'd2050, 12'd2049, 12'd2048}, tc: 16'd5,
                ch0: 4'd1, ch1: 4'd9, slot: 1'b1, r0: 12'd2, r1: 12'd2049};
    vecs[4] = '{d0: {12'd40, 12'd30, 12'd20, 12'd10}, d1: {12'd4, 12'd0, 12'd0, 12'd0}, tc: 16'd7,
                ch0: 4'd0, ch1: 4'd8, slot: 1'b0, r0: 12'd25, r1: 12'd1};
    vecs[5] = '{d0: {12'd1, 12'd1, 12'd1, 12'd0}, d1: {12'd10, 12'd10, 12'd10, 12'd11}, tc: 16'd2,
                ch0: 4'd0, ch1: 4'd8, slot: 1'b0, r0: 12'd0, r1: 12'd10};
    vecs[6] = '{d0: {12'd13, 12'd12, 12'd11, 12'd10}, d1: {12'd1001, 12'd1000, 12'd1000, 12'd1000}, tc: 16'd4,
                ch0: 4'd0, ch1: 4'd8, slot: 1'b0, r0: 12'd11, r1: 12'd1000};
    vecs[7] = '{d0: {12'd400, 12'd300, 12'd200, 12'd100}, d1: {4{12'd7}}, tc: 16'(TIMEOUT),
                ch0: 4'd1, ch1: 4'd9, slot: 1'b1, r0: 12'd250, r1: 12'd7};

    resetn = 1'b0; enable = 1'b1; cal_rdy = 1'b1; eoc = 1'b0; err_clr = 1'b0;
    d0 = 12'd0; d1 = 12'd0;
    en_b = 1'b0; cal_b = 1'b1; eoc_b = 1'b0; clr_b = 1'b0; d0_b = 12'd4095; d1_b = 12'd0;

    repeat (3) @(negedge clk);
    check_reset();
    resetn = 1'b1;
    wait_soc(1'b0, n);
    check("first_soc_delay", n, SETTLE + 2);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_soc(1'b0, n);
        check("slot_soc_delay", n, SETTLE + 1);
      end
      run_vec(vecs[i]);
    end

    // Calibration not ready: stay busy, no conversions
    enable = 1'b0; cal_rdy = 1'b0;
    @(negedge clk);
    check("idle_convstop", convstop, 1);
    check("idle_busy", busy, 0);
    enable = 1'b1;
    s0 = soc_cnt;
    repeat (50) @(negedge clk);
    check("cal_wait_busy", busy, 1);
    check("cal_wait_no_soc", soc_cnt - s0, 0);
    cal_rdy = 1'b1;
    wait_soc(1'b0, n);
    check("cal_soc_delay", n, SETTLE + 1);
    run_vec(vecs[4]);

    // Slot 1 first sample never completes
    wait_soc(1'b0, n);
    check("slot_soc_delay", n, SETTLE + 1);
    v0 = valid_cnt;
    repeat (TIMEOUT - 1) @(negedge clk);
    @(negedge clk);
    check("to_err_before", err, 0);
    check("to_convstop_before", convstop, 0);
    @(negedge clk);
    check("to_err_set", err, 1);
    check("to_convstop_pulse", convstop, 1);
    check("to_ch0_slot0", ch0, 0);
    check("to_ch1_slot0", ch1, 8);
    @(negedge clk);
    check("to_convstop_end", convstop, 0);
    wait_soc(1'b0, n);
    check("to_resume_delay", n, 3);
    check("to_no_result", valid_cnt - v0, 0);
    check("to_err_sticky", err, 1);
    run_vec(vecs[5]);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", err, 0);
    wait_soc(1'b0, n);
    check("slot_soc_delay_clr", n, SETTLE);

    // Drop enable during the third sample's EOC cycle
    v0 = valid_cnt;
    do_sample(12'd4000, 12'd4000, 6);
    @(negedge clk);
    check("abort_soc2", soc, 1);
    do_sample(12'd4000, 12'd4000, 6);
    @(negedge clk);
    check("abort_soc3", soc, 1);
    repeat (6) @(negedge clk);
    eoc = 1'b1; enable = 1'b0; d0 = 12'd4000; d1 = 12'd4000;
    @(negedge clk);
    eoc = 1'b0;
    check("abort_convstop", convstop, 1);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("abort_no_result", valid_cnt - v0, 0);
    enable = 1'b1;
    wait_soc(1'b0, n);
    check("reenable_soc_delay", n, SETTLE + 2);
    run_vec(vecs[6]);

    // Stray EOC during SETUP, then EOC exactly in the timeout expiry cycle
    @(negedge clk);
    eoc = 1'b1; d0 = 12'd999; d1 = 12'd999;
    @(negedge clk);
    eoc = 1'b0;
    wait_soc(1'b0, n);
    check("stray_soc_delay", n, 3);
    run_vec(vecs[7]);
    check("edge_eoc_no_err", err, 0);

    // Reset in the middle of a conversion
    wait_soc(1'b0, n);
    check("slot_soc_delay", n, SETTLE + 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset();
    repeat (2) @(negedge clk);
    enable = 1'b0;
    resetn = 1'b1;

    // Single-sample averaging: every EOC yields a result, slots alternate
    en_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_soc(1'b1, n);
      repeat (2) @(negedge clk);
      eoc_b = 1'b1;
      @(negedge clk);
      eoc_b = 1'b0;
      @(negedge clk);
      check("avg1_valid", valid_b, 1);
      check("avg1_res0", r0_b, 4095);
      check("avg1_res1", r1_b, 0);
      check("avg1_slot", rslot_b, k % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Sequences the on-chip dual ADC through a fixed two-slot scan list, one channel per ADC per slot. It drives channel selects, start-of-conversion and conversion-stop, and waits for end-of-conversion with a timeout. Each slot accumulates 2^AVG_LOG2 sample pairs and presents the averaged pair with a valid strobe. It sits between the ADC hard-macro wrapper and the fabric logic that consumes camera/PoF analog readings, running on the same fabric clock as the ADC's `fab_clk_i`.

## Interface
- AVG_LOG2, 2: log2 of samples averaged per slot; legal range 0..4.
- SETTLE_CYC, 4: cycles channel selects are held stable before SOC; legal range 1..255.
- TIMEOUT_CYC, 1024: cycles allowed from SOC to EOC before abort; legal range 16..65535.
- S0_CH0 / S0_CH1, 4'd0 / 4'd8: slot 0 selects for ADC0 / ADC1.
- S1_CH0 / S1_CH1, 4'd1 / 4'd9: slot 1 selects for ADC0 / ADC1.
- clk_i  in  1  fabric clock, same net as ADC fab_clk_i.
- resetn_i  in  1  reset, synchronous, active-low.
- enable_i  in  1  scan enable, level.
- cal_rdy_i  in  1  ADC calibration-ready (adc_calrdy_o).
- adc_eoc_i  in  1  end-of-conversion, single-cycle pulse.
- adc0_data_i  in  12  ADC0 result, valid in the EOC cycle.
- adc1_data_i  in  12  ADC1 result, valid in the EOC cycle.
- err_clr_i  in  1  clears err_timeout_o.
- adc0_ch_sel_o  out  4  ADC0 channel select.
- adc1_ch_sel_o  out  4  ADC1 channel select.
- adc_soc_o  out  1  start-of-conversion, single-cycle pulse.
- adc_convstop_o  out  1  conversion stop, active-high.
- res_valid_o  out  1  single-cycle strobe; averaged result pair available.
- res_slot_o  out  1  slot index of the result.
- res0_o  out  12  averaged ADC0 result.
- res1_o  out  12  averaged ADC1 result.
- err_timeout_o  out  1  sticky timeout flag.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT_CAL, SETUP, START, WAIT_EOC, CAPTURE, EMIT.
- IDLE: convstop=1, slot=0, accumulators and sample count cleared. When enable_i=1, go to WAIT_CAL.
- WAIT_CAL: stay until cal_rdy_i=1, then go to SETUP.
- SETUP: drive the ch_sel outputs from the current slot's parameters; convstop=0; settle counter counts SETTLE_CYC cycles, then go to START.
- START: adc_soc_o=1 for exactly this cycle; timeout counter cleared; go to WAIT_EOC.
- WAIT_EOC: on adc_eoc_i=1, register both data inputs and go to CAPTURE.
  - If the timeout counter reaches TIMEOUT_CYC-1 with no EOC: set err_timeout_o, pulse convstop=1 for one cycle, discard the slot's accumulators and count, advance slot, go to SETUP.
- CAPTURE: acc0+=d0, acc1+=d1. Accumulators are 12+AVG_LOG2 bits and never overflow. Increment the sample count.
  - If count == 2^AVG_LOG2: go to EMIT.
  - Otherwise go to START (channels unchanged, no re-settle).
- EMIT: res0_o=acc0>>AVG_LOG2, res1_o=acc1>>AVG_LOG2 (truncating), res_slot_o=slot, res_valid_o=1 for one cycle. Clear accumulators and count, toggle slot, go to SETUP.
- Slot order is 0,1,0,1,…; slot wraps from 1 to 0.
- res0_o, res1_o and res_slot_o hold their values until the next EMIT.
- enable_i=0 in any non-IDLE state: go to IDLE next cycle. Partial accumulation is discarded, no result is emitted, convstop=1. An EOC arriving in that same cycle is ignored.
- cal_rdy_i is checked only in WAIT_CAL.
- err_timeout_o: set wins over err_clr_i in the same cycle. Otherwise err_clr_i=1 clears it.
- Unexpected adc_eoc_i outside WAIT_EOC is ignored.

## Timing
- Reset values (resetn_i low at a clk_i edge):
  - state=IDLE, slot=0.
  - adc0_ch_sel_o=S0_CH0, adc1_ch_sel_o=S0_CH1.
  - adc_soc_o=0, adc_convstop_o=1.
  - res_valid_o=0, res_slot_o=0, res0_o=0, res1_o=0.
  - err_timeout_o=0, busy_o=0.
- Reset mid-conversion behaves identically to reset from idle.
- All outputs are registered.
- ch_sel outputs change only on entry to SETUP, at least SETTLE_CYC cycles before SOC.
- EOC and timeout expiry in the same cycle: EOC wins, no error.
- Per-sample loop: START(1) + WAIT_EOC(Tc, cycles from SOC to EOC inclusive) + CAPTURE(1).
- Slot period: SETTLE_CYC + 2^AVG_LOG2·(Tc+2) + 1 (EMIT) cycles.
- res_valid_o is asserted in the cycle after the final CAPTURE.
- Enable to first SOC, with cal_rdy_i already high: 1 (WAIT_CAL) + SETTLE_CYC cycles after IDLE exits.

## Test plan
- Reset held with enable_i=1, then released; model EOC 20 cycles after each SOC; data ADC0=100,101,102,103 and ADC1=4000 ×4.
  - Expect one SOC per sample, ch_sel 0/8.
  - Expect res_valid_o with res_slot_o=0, res0_o=101, res1_o=4000.
  - Next slot drives ch_sel 1/9.
- cal_rdy_i=0 for 50 cycles after enable -> busy_o=1, no SOC. First SOC occurs 1+SETTLE_CYC cycles after cal_rdy_i rises.
- Suppress EOC for slot 1, first sample -> err_timeout_o set TIMEOUT_CYC cycles after SOC. convstop pulses once, no res_valid_o for slot 1, scan resumes at slot 0. err_clr_i clears the flag.
- Deassert enable_i during WAIT_EOC of sample 3; fire EOC in that cycle -> IDLE, convstop=1, no result. Re-enable produces a fresh slot-0 average unaffected by the old samples.
- AVG_LOG2=0, data 4095/0 -> every EOC yields res_valid_o with 4095/0 and alternating res_slot_o.
- EOC in the exact timeout-expiry cycle -> sample accepted, err_timeout_o stays 0; stray EOC pulses in SETUP are ignored.
